// File: rtl/vga_raster_ctrl.sv
// -----------------------------------------------------------------------------
// vga_raster_ctrl
//
// Parametrised VGA raster controller for the DE2-70 ADV7123 DAC path.
// Generates H/V timing, issues a pixel-request stream with active-area
// coordinates to the host pixel generator, and realigns sync/blank to the
// host colour, which returns PIX_LAT (0..7) clocks after each request.
//
// Optional feature macro: VGA_RASTER_TEST_PATTERN_EN
//   When defined and iTest=1, the host colour is replaced by 8 vertical
//   colour bars (white, yellow, cyan, green, magenta, red, blue, black).
//   When undefined, iTest is ignored.
//
// Ports:
//   iCLK, iRST_N             pixel clock, async active-low reset
//   iRed/iGreen/iBlue        host colour, sampled PIX_LAT clocks after oReq
//   iTest                    test-pattern select
//   oReq, oCoord_X/Y         pixel request and its active-area coordinates
//   oFrame_start             one-clock pulse with the request for (0,0)
//   oVGA_R/G/B               DAC colour
//   oVGA_H_SYNC/V_SYNC       syncs at the configured polarity
//   oVGA_BLANK               active-low blank (low outside the active area)
//   oVGA_SYNC                tied low
//   oVGA_CLOCK               equal to iCLK
// -----------------------------------------------------------------------------
module vga_raster_ctrl #(
  parameter int COLOR_W = 10,
  parameter int CNT_W   = 11,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int PIX_LAT = 1
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  input  logic               iTest,
  output logic               oReq,
  output logic [CNT_W-1:0]   oCoord_X,
  output logic [CNT_W-1:0]   oCoord_Y,
  output logic               oFrame_start,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_B   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_E   = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] V_ACT_B   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_E   = CNT_W'(V_SYNC + V_BP + V_ACT);

`ifdef VGA_RASTER_TEST_PATTERN_EN
  localparam int BAR_BITS = 3;
  localparam int PROD_W   = CNT_W + 3;
`else
  localparam int BAR_BITS = 0;
`endif
  // Delay-line word: {bar index (optional), hsync, vsync, active}
  localparam int DL_W = 3 + BAR_BITS;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  logic             cur_act;
  logic             cur_hs;
  logic             cur_vs;
  logic [CNT_W-1:0] cur_x;
  logic [CNT_W-1:0] cur_y;

  assign cur_act = (h_cnt >= H_ACT_B) && (h_cnt < H_ACT_E) &&
                   (v_cnt >= V_ACT_B) && (v_cnt < V_ACT_E);
  assign cur_hs  = (h_cnt < H_SYNC_E);   // internal sync flags are active-high
  assign cur_vs  = (v_cnt < V_SYNC_E);
  assign cur_x   = h_cnt - H_ACT_B;
  assign cur_y   = v_cnt - V_ACT_B;

  // ---------------------------------------------------------------------------
  // Stage 1: request stream to the host
  // ---------------------------------------------------------------------------
  logic s1_hs;
  logic s1_vs;
  logic [DL_W-1:0] s1_vec;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oReq         <= 1'b0;
      oCoord_X     <= '0;
      oCoord_Y     <= '0;
      oFrame_start <= 1'b0;
      s1_hs        <= 1'b0;
      s1_vs        <= 1'b0;
    end else begin
      oReq         <= cur_act;
      oFrame_start <= cur_act && (h_cnt == H_ACT_B) && (v_cnt == V_ACT_B);
      s1_hs        <= cur_hs;
      s1_vs        <= cur_vs;
      // Coordinates hold through blanking so the host never sees garbage.
      if (cur_act) begin
        oCoord_X <= cur_x;
        oCoord_Y <= cur_y;
      end
    end
  end

`ifdef VGA_RASTER_TEST_PATTERN_EN
  logic [2:0] s1_bar;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_bar <= '0;
    end else begin
      s1_bar <= 3'((({3'b000, cur_x}) << 3) / PROD_W'(H_ACT));
    end
  end

  assign s1_vec = {s1_bar, s1_hs, s1_vs, oReq};
`else
  assign s1_vec = {s1_hs, s1_vs, oReq};
`endif

  // ---------------------------------------------------------------------------
  // Delay line: matches sync/blank to the host colour latency
  // ---------------------------------------------------------------------------
  logic [DL_W-1:0] dly_vec;

  if (PIX_LAT == 0) begin : g_no_dly
    assign dly_vec = s1_vec;
  end else begin : g_dly
    logic [PIX_LAT-1:0][DL_W-1:0] dl;

    // NOTE: the delay line is reset (not left free-running) so that a reset
    // mid-frame restarts it empty and no stale pixel reaches the DAC.
    always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
        dl <= '0;
      end else begin
        dl[0] <= s1_vec;
        for (int i = 1; i < PIX_LAT; i++) begin
          dl[i] <= dl[i-1];
        end
      end
    end

    assign dly_vec = dl[PIX_LAT-1];
  end

  logic d_hs;
  logic d_vs;
  logic d_act;

  assign {d_hs, d_vs, d_act} = dly_vec[2:0];

  // ---------------------------------------------------------------------------
  // Colour select
  // ---------------------------------------------------------------------------
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;

`ifdef VGA_RASTER_TEST_PATTERN_EN
  logic [2:0] bar_rgb;

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    case (dly_vec[5:3])
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end
`else
  logic unused_test;
  assign unused_test = iTest;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (d_act) begin
      pix_r = iRed;
      pix_g = iGreen;
      pix_b = iBlue;
`ifdef VGA_RASTER_TEST_PATTERN_EN
      if (iTest) begin
        pix_r = {COLOR_W{bar_rgb[2]}};
        pix_g = {COLOR_W{bar_rgb[1]}};
        pix_b = {COLOR_W{bar_rgb[0]}};
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: colour, sync and blank change on the same edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_R      <= '0;
      oVGA_G      <= '0;
      oVGA_B      <= '0;
      oVGA_H_SYNC <= ~HS_POL;
      oVGA_V_SYNC <= ~VS_POL;
      oVGA_BLANK  <= 1'b0;
    end else begin
      oVGA_R      <= pix_r;
      oVGA_G      <= pix_g;
      oVGA_B      <= pix_b;
      oVGA_H_SYNC <= d_hs ? HS_POL : ~HS_POL;
      oVGA_V_SYNC <= d_vs ? VS_POL : ~VS_POL;
      oVGA_BLANK  <= d_act;
    end
  end

  assign oVGA_SYNC  = 1'b0;
  assign oVGA_CLOCK = iCLK;

endmodule

// File: tb/tb_vga_raster_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_raster_ctrl
//
// Two instances on a small raster (H 2/2/4/2, V 1/1/3/1 -> H_TOT=10, V_TOT=6):
//   dut  : active-low syncs, PIX_LAT=3, host returns {X, Y} delayed 3 clocks
//   dut2 : active-high syncs, PIX_LAT=0, host returns X combinationally
// Cycle k is the interval after the k-th rising edge following reset release;
// the counters then hold C=k, so stage-1 shows C=k-1 and the pins show
// C=k-PIX_LAT-2. Expected values below are hand-derived from that relation.
// -----------------------------------------------------------------------------
module tb_vga_raster_ctrl;

  localparam int CW = 10;
  localparam int NW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_sel = 1'b0;

  always #5 clk = ~clk;

  // ---- instance 1 ----
  logic [CW-1:0] red, green, blue;
  logic          req, fs, hs, vs, blk, vsync_pin, vclk;
  logic [NW-1:0] cx, cy;
  logic [CW-1:0] vr, vg, vb;

  // ---- instance 2 ----
  logic [CW-1:0] red2;
  logic          req2, fs2, hs2, vs2, blk2, vsync_pin2, vclk2;
  logic [NW-1:0] cx2, cy2;
  logic [CW-1:0] vr2, vg2, vb2;

  // Host model for instance 1: hx[i] holds X from i cycles ago.
  logic [NW-1:0] hx[4];
  logic [NW-1:0] hy[4];

  assign red   = hx[3][CW-1:0];
  assign green = hy[3][CW-1:0];
  assign blue  = 10'h155;
  assign red2  = cx2[CW-1:0];

  vga_raster_ctrl #(
    .COLOR_W(CW), .CNT_W(NW),
    .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(3)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iRed(red), .iGreen(green), .iBlue(blue), .iTest(test_sel),
    .oReq(req), .oCoord_X(cx), .oCoord_Y(cy), .oFrame_start(fs),
    .oVGA_R(vr), .oVGA_G(vg), .oVGA_B(vb),
    .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_BLANK(blk),
    .oVGA_SYNC(vsync_pin), .oVGA_CLOCK(vclk)
  );

  vga_raster_ctrl #(
    .COLOR_W(CW), .CNT_W(NW),
    .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(0)
  ) dut2 (
    .iCLK(clk), .iRST_N(rst_n),
    .iRed(red2), .iGreen('0), .iBlue('0), .iTest(1'b0),
    .oReq(req2), .oCoord_X(cx2), .oCoord_Y(cy2), .oFrame_start(fs2),
    .oVGA_R(vr2), .oVGA_G(vg2), .oVGA_B(vb2),
    .oVGA_H_SYNC(hs2), .oVGA_V_SYNC(vs2), .oVGA_BLANK(blk2),
    .oVGA_SYNC(vsync_pin2), .oVGA_CLOCK(vclk2)
  );

  initial begin
    for (int i = 0; i < 4; i++) begin
      hx[i] = '0;
      hy[i] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 3; i > 0; i--) begin
        hx[i] = hx[i-1];
        hy[i] = hy[i-1];
      end
      hx[0] = cx;
      hy[0] = cy;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    #1;
  endtask

  typedef enum int {
    S_REQ, S_X, S_Y, S_FS, S_HS, S_VS, S_BLK, S_R, S_G,
    S_HS2, S_VS2, S_BLK2, S_R2
  } sig_e;

  typedef struct {
    int          k;
    sig_e        sig;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_REQ:   return 32'(req);
      S_X:     return 32'(cx);
      S_Y:     return 32'(cy);
      S_FS:    return 32'(fs);
      S_HS:    return 32'(hs);
      S_VS:    return 32'(vs);
      S_BLK:   return 32'(blk);
      S_R:     return 32'(vr);
      S_G:     return 32'(vg);
      S_HS2:   return 32'(hs2);
      S_VS2:   return 32'(vs2);
      S_BLK2:  return 32'(blk2);
      default: return 32'(vr2);
    endcase
  endfunction

  vec_t tbl[$];

  task automatic add(input int k, input sig_e s, input logic [31:0] e);
    vec_t v;
    v.k = k;
    v.sig = s;
    v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin : main
    int reqs, fss, px, waited;

    // ---- vector table (sorted by cycle) ----
    add(0,  S_REQ, 0); add(0, S_HS, 1); add(0, S_VS, 1); add(0, S_BLK, 0);
    add(0,  S_HS2, 0); add(0, S_VS2, 0);
    add(2,  S_HS2, 1); add(2, S_VS2, 1);
    add(4,  S_HS, 1);  add(4, S_VS, 1); add(4, S_HS2, 0);
    add(5,  S_HS, 0);  add(5, S_VS, 0); add(5, S_BLK, 0);
    add(7,  S_HS, 1);  add(7, S_VS, 0);
    add(12, S_HS2, 1); add(12, S_VS2, 0);
    add(15, S_HS, 0);  add(15, S_VS, 1);
    add(25, S_REQ, 1); add(25, S_X, 0); add(25, S_Y, 0); add(25, S_FS, 1);
    add(25, S_HS, 0);  add(25, S_BLK, 0);
    add(26, S_REQ, 1); add(26, S_X, 1); add(26, S_FS, 0);
    add(26, S_BLK2, 1); add(26, S_R2, 0);
    add(27, S_R2, 1);
    add(28, S_X, 3);
    add(29, S_REQ, 0); add(29, S_X, 3); add(29, S_BLK, 1); add(29, S_R, 0); add(29, S_G, 0);
    add(30, S_R, 1);
    add(32, S_R, 3);
    add(33, S_BLK, 0); add(33, S_R, 0);
    add(35, S_REQ, 1); add(35, S_X, 0); add(35, S_Y, 1); add(35, S_HS, 0);
    add(41, S_R, 2);   add(41, S_G, 1);
    add(48, S_X, 3);   add(48, S_Y, 2);
    add(52, S_BLK, 1); add(52, S_R, 3); add(52, S_G, 2);
    add(55, S_REQ, 0); add(55, S_X, 3); add(55, S_Y, 2);
    add(61, S_BLK, 0); add(61, S_HS, 1); add(61, S_VS, 1);
    add(65, S_HS, 0);  add(65, S_VS, 0);
    add(85, S_REQ, 1); add(85, S_X, 0); add(85, S_Y, 0); add(85, S_FS, 1);

    // ---- initial reset ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_hs2_idle_low", 32'(hs2), 0);
    check("rst_vs2_idle_low", 32'(vs2), 0);
    check("vga_sync_tied", 32'(vsync_pin), 0);
    release_reset();

    foreach (tbl[i]) begin
      while (cyc < tbl[i].k) tick();
      check($sformatf("vec%0d_sig%0d", i, int'(tbl[i].sig)), sample(tbl[i].sig), tbl[i].exp);
    end

    // ---- one full frame: request count, frame pulse, pixel alignment ----
    reqs = 0;
    fss  = 0;
    px   = 0;
    repeat (60) begin
      tick();
      if (req) reqs++;
      if (fs)  fss++;
      if (blk) begin
        check("align_r", 32'(vr), 32'(px));
        px++;
      end else begin
        check("blank_r_zero", 32'(vr), 0);
        px = 0;
      end
    end
    check("frame_req_count", 32'(reqs), 12);
    check("frame_start_count", 32'(fss), 1);

    // ---- reset asserted mid-frame for 5 clocks ----
    while (!req) tick();       // bounded: a request occurs within every line
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(req), 0);
    check("mid_rst_x", 32'(cx), 0);
    check("mid_rst_y", 32'(cy), 0);
    check("mid_rst_fs", 32'(fs), 0);
    check("mid_rst_hs", 32'(hs), 1);
    check("mid_rst_vs", 32'(vs), 1);
    check("mid_rst_blk", 32'(blk), 0);
    check("mid_rst_r", 32'(vr), 0);
    check("mid_rst_hs2", 32'(hs2), 0);
    repeat (5) @(posedge clk);
`ifdef VGA_RASTER_TEST_PATTERN_EN
    test_sel = 1'b1;
`endif
    release_reset();
    waited = 0;
    while (!req && waited < 200) begin
      tick();
      waited++;
    end
    check("first_req_latency", 32'(waited), 25);
    check("first_req_x", 32'(cx), 0);
    check("first_req_y", 32'(cy), 0);
    check("first_req_fs", 32'(fs), 1);

`ifdef VGA_RASTER_TEST_PATTERN_EN
    // H_ACT=4: bar index = 2*X -> white, cyan, magenta, blue
    while (cyc < 29) tick();
    check("bar_x0_r", 32'(vr), 32'h3ff); check("bar_x0_g", 32'(vg), 32'h3ff); check("bar_x0_b", 32'(vb), 32'h3ff);
    tick();
    check("bar_x1_r", 32'(vr), 0);       check("bar_x1_g", 32'(vg), 32'h3ff); check("bar_x1_b", 32'(vb), 32'h3ff);
    tick();
    check("bar_x2_r", 32'(vr), 32'h3ff); check("bar_x2_g", 32'(vg), 0);       check("bar_x2_b", 32'(vb), 32'h3ff);
    tick();
    check("bar_x3_r", 32'(vr), 0);       check("bar_x3_g", 32'(vg), 0);       check("bar_x3_b", 32'(vb), 32'h3ff);
    test_sel = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
